// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM for a multicycle RV32I-subset datapath
module multicycle_control_fsm (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOP,
   output logic [1:0] ImmSrc,
   output logic       IllegalOp
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
   } state_t;

   state_t state;
   logic   pcupdate;
   logic   branch;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:    if (MemReady) state <= S_DECODE;
            S_DECODE:
               case (op)
                  OP_LW, OP_SW: state <= S_MEMADR;
                  OP_R:         state <= S_EXECR;
                  OP_I:         state <= S_EXECI;
                  OP_BEQ:       state <= S_BEQ;
                  OP_JAL:       state <= S_JAL;
                  default:      state <= S_FETCH;
               endcase
            S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD :
                                 (op == OP_SW) ? S_MEMWRITE : S_FETCH;
            S_MEMREAD:  if (MemReady) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWRITE: if (MemReady) state <= S_FETCH;
            S_EXECR:    state <= S_ALUWB;
            S_EXECI:    state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BEQ:      state <= S_FETCH;
            S_JAL:      state <= S_ALUWB;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // Outputs decode the state register; a low RST overrides them in the same cycle.
   always_comb begin
      pcupdate  = 1'b0;
      branch    = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOP     = 2'b00;
      IllegalOp = 1'b0;
      case (state)
         S_FETCH: begin
            IRWrite   = MemReady;
            pcupdate  = MemReady;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         S_DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b01;
            IllegalOp = !(op == OP_LW || op == OP_SW || op == OP_R ||
                          op == OP_I  || op == OP_BEQ || op == OP_JAL);
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOP   = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOP   = 2'b10;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOP   = 2'b01;
            branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA  = 2'b01;
            ALUSrcB  = 2'b10;
            pcupdate = 1'b1;
         end
         default: ;
      endcase
      if (!RST) begin
         pcupdate  = 1'b0;
         branch    = 1'b0;
         IRWrite   = 1'b0;
         RegWrite  = 1'b0;
         MemWrite  = 1'b0;
         IllegalOp = 1'b0;
         AdrSrc    = 1'b0;
         ResultSrc = 2'b10;
         ALUSrcA   = 2'b00;
         ALUSrcB   = 2'b10;
         ALUOP     = 2'b00;
      end
   end

   assign PCWrite = pcupdate | (branch & Zero);

   always_comb begin
      case (op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - directed self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic [6:0] op;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, IllegalOp;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOP, ImmSrc;

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   multicycle_control_fsm dut (
      .CLK(CLK), .RST(RST), .op(op), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOP(ALUOP), .ImmSrc(ImmSrc), .IllegalOp(IllegalOp)
   );

   // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc}_ResultSrc_ALUSrcA_ALUSrcB_ALUOP_IllegalOp
   logic [13:0] obs;
   assign obs = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOP, IllegalOp};

   localparam logic [13:0] E_FETCH  = 14'b11000_10_00_10_00_0;
   localparam logic [13:0] E_STALL  = 14'b00000_10_00_10_00_0;
   localparam logic [13:0] E_RESET  = 14'b00000_10_00_10_00_0;
   localparam logic [13:0] E_DECODE = 14'b00000_00_01_01_00_0;
   localparam logic [13:0] E_ILL    = 14'b00000_00_01_01_00_1;
   localparam logic [13:0] E_MEMADR = 14'b00000_00_10_01_00_0;
   localparam logic [13:0] E_MEMRD  = 14'b00001_00_00_00_00_0;
   localparam logic [13:0] E_MEMWB  = 14'b00100_01_00_00_00_0;
   localparam logic [13:0] E_MEMWR  = 14'b00011_00_00_00_00_0;
   localparam logic [13:0] E_EXECR  = 14'b00000_00_10_00_10_0;
   localparam logic [13:0] E_EXECI  = 14'b00000_00_10_01_10_0;
   localparam logic [13:0] E_ALUWB  = 14'b00100_00_00_00_00_0;
   localparam logic [13:0] E_BEQ1   = 14'b10000_00_10_00_01_0;
   localparam logic [13:0] E_BEQ0   = 14'b00000_00_10_00_01_0;
   localparam logic [13:0] E_JAL    = 14'b10000_00_01_10_00_0;

   task automatic test_reset();
      RST = 1'b0; op = 7'b0000011; Zero = 1'b1; MemReady = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      @(negedge CLK);
      checks++;
      if (obs !== E_RESET) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=%b", obs, E_RESET);
      end
      checks++;
      if (ImmSrc !== 2'b00) begin
         failures++;
         $display("FAIL reset_immsrc got=%b want=00", ImmSrc);
      end
      @(posedge CLK); #1;
      RST = 1'b1;
   endtask

   task automatic test_lw();
      logic [13:0] ev [12];
      logic        mr [12];
      ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB,
             E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMWB, E_STALL};
      mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      op = 7'b0000011; Zero = 1'b0;
      for (int i = 0; i < 12; i++) begin
         MemReady = mr[i];
         @(negedge CLK);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL lw[%0d] got=%b want=%b", i, obs, ev[i]);
         end
         checks++;
         if (ImmSrc !== 2'b00) begin
            failures++;
            $display("FAIL lw_immsrc[%0d] got=%b want=00", i, ImmSrc);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_beq();
      logic [13:0] ev [6];
      logic        zv [6];
      ev = '{E_FETCH, E_DECODE, E_BEQ1, E_FETCH, E_DECODE, E_BEQ0};
      zv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      op = 7'b1100011; MemReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         Zero = zv[i];
         @(negedge CLK);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL beq[%0d] got=%b want=%b", i, obs, ev[i]);
         end
         checks++;
         if (ImmSrc !== 2'b10) begin
            failures++;
            $display("FAIL beq_immsrc[%0d] got=%b want=10", i, ImmSrc);
         end
         @(posedge CLK); #1;
      end
      Zero = 1'b0;
   endtask

   task automatic test_sw_stall();
      logic [13:0] ev [8];
      logic        mr [8];
      ev = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR, E_STALL};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      op = 7'b0100011; Zero = 1'b0;
      for (int i = 0; i < 8; i++) begin
         MemReady = mr[i];
         @(negedge CLK);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL sw[%0d] got=%b want=%b", i, obs, ev[i]);
         end
         checks++;
         if (ImmSrc !== 2'b01) begin
            failures++;
            $display("FAIL sw_immsrc[%0d] got=%b want=01", i, ImmSrc);
         end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_fetch_stall_i();
      logic [13:0] ev [7];
      logic        mr [7];
      ev = '{E_STALL, E_STALL, E_FETCH, E_DECODE, E_EXECI, E_ALUWB, E_STALL};
      mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      op = 7'b0010011; Zero = 1'b1;
      for (int i = 0; i < 7; i++) begin
         MemReady = mr[i];
         @(negedge CLK);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL itype[%0d] got=%b want=%b", i, obs, ev[i]);
         end
         @(posedge CLK); #1;
      end
      Zero = 1'b0;
   endtask

   task automatic test_illegal();
      logic [13:0] ev [3];
      logic        mr [3];
      ev = '{E_FETCH, E_ILL, E_STALL};
      mr = '{1'b1, 1'b1, 1'b0};
      op = 7'b1111111; Zero = 1'b1;
      for (int i = 0; i < 3; i++) begin
         MemReady = mr[i];
         @(negedge CLK);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL illegal[%0d] got=%b want=%b", i, obs, ev[i]);
         end
         checks++;
         if (ImmSrc !== 2'b00) begin
            failures++;
            $display("FAIL illegal_immsrc[%0d] got=%b want=00", i, ImmSrc);
         end
         @(posedge CLK); #1;
      end
      Zero = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [13:0] ev [9];
      logic        rv [9];
      ev = '{E_FETCH, E_DECODE, E_RESET, E_RESET, E_FETCH, E_DECODE, E_EXECR, E_ALUWB, E_STALL};
      rv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      op = 7'b0110011; Zero = 1'b0;
      for (int i = 0; i < 9; i++) begin
         RST = rv[i];
         MemReady = (i == 8) ? 1'b0 : 1'b1;
         @(negedge CLK);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL reset_mid[%0d] got=%b want=%b", i, obs, ev[i]);
         end
         @(posedge CLK); #1;
      end
      RST = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [13:0] ev [9];
      logic [6:0]  ov [9];
      logic [1:0]  iv [9];
      ev = '{E_FETCH, E_DECODE, E_EXECR, E_ALUWB,
             E_FETCH, E_DECODE, E_JAL, E_ALUWB, E_STALL};
      ov = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
             7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
      iv = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
      Zero = 1'b0;
      for (int i = 0; i < 9; i++) begin
         op = ov[i];
         MemReady = (i == 8) ? 1'b0 : 1'b1;
         @(negedge CLK);
         checks++;
         if (obs !== ev[i]) begin
            failures++;
            $display("FAIL b2b[%0d] got=%b want=%b", i, obs, ev[i]);
         end
         checks++;
         if (ImmSrc !== iv[i]) begin
            failures++;
            $display("FAIL b2b_immsrc[%0d] got=%b want=%b", i, ImmSrc, iv[i]);
         end
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_beq();
      test_sw_stall();
      test_fetch_stall_i();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-low.
REQ-004 op  input  7  opcode from the instruction register; stable from DECODE until the instruction completes.
REQ-005 Zero  input  1  ALU zero flag, used only in BEQ.
REQ-006 MemReady  input  1  memory handshake; 1 = access completes this cycle.
REQ-007 PCWrite  output  1  PC register enable.
REQ-008 IRWrite  output  1  instruction register enable.
REQ-009 RegWrite  output  1  register file write enable.
REQ-010 MemWrite  output  1  data memory write enable.
REQ-011 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-012 ResultSrc  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-013 ALUSrcA  output  2  ALU A mux select: 00 = PC, 01 = OldPC, 10 = rs1.
REQ-014 ALUSrcB  output  2  ALU B mux select: 00 = rs2, 01 = Imm, 10 = constant 4.
REQ-015 ALUOP  output  2  ALU operation class to the ALU decoder: 00 = add, 01 = sub, 10 = per funct.
REQ-016 ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-017 IllegalOp  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-018 Control SHALL be a Moore FSM with 11 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-019 Supported opcodes SHALL be: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
REQ-020 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOP=00, ResultSrc=10, PC update; go to DECODE only when MemReady=1, else hold FETCH with IRWrite and PC update suppressed.
REQ-021 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOP=00; next state: lw/sw->MEMADR, R->EXECR, I->EXECI, beq->BEQ, jal->JAL, other->FETCH with IllegalOp=1 for this cycle.
REQ-022 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOP=00; lw->MEMREAD, sw->MEMWRITE.
REQ-023 MEMREAD: AdrSrc=1, ResultSrc=00; go to MEMWB when MemReady=1, else hold.
REQ-024 MEMWB: ResultSrc=01, RegWrite=1; go to FETCH.
REQ-025 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1; go to FETCH when MemReady=1, else hold with MemWrite kept at 1.
REQ-026 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOP=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOP=10. Both go to ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegWrite=1; go to FETCH.
REQ-028 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOP=01, ResultSrc=00, branch active; go to FETCH.
REQ-029 JAL: ALUSrcA=01, ALUSrcB=10, ALUOP=00, ResultSrc=00, PC update; go to ALUWB.
REQ-030 PCWrite SHALL equal PCUpdate OR (Branch AND Zero).
REQ-031 Any field not listed for a state SHALL be driven to 0.
REQ-032 ImmSrc SHALL be combinational from op: lw/I-ALU->00, sw->01, beq->10, jal->11, others->00.
REQ-033 Latencies in cycles SHALL be, with MemReady=1 throughout: lw 5, sw 4, R/I 4, beq 3, jal 4.

Reset
REQ-034 While RST=0 at a rising edge, the state SHALL become FETCH, regardless of current state (including mid-instruction or during a MemReady stall).
REQ-035 While RST=0, PCWrite, IRWrite, RegWrite, MemWrite and IllegalOp SHALL be forced to 0; the other outputs SHALL take their FETCH values.
REQ-036 On the first edge after RST returns to 1, the block SHALL perform a normal FETCH.

Verification
REQ-037 lw (op=0000011), MemReady=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
REQ-038 beq with Zero=1 -> PCWrite=1 in cycle 3 with ALUOP=01; repeat with Zero=0 -> PCWrite=0 in cycle 3.
REQ-039 sw with MemReady low for 3 cycles in MEMWRITE -> MemWrite held at 1 for 4 cycles; then FETCH; RegWrite stays 0.
REQ-040 op=1111111 -> IllegalOp=1 for exactly the DECODE cycle; next state FETCH; no write enable asserted.
REQ-041 RST=0 asserted in EXECR -> all enables 0 in the same cycle, state FETCH on the next edge; after release, IRWrite=1 in FETCH.
REQ-042 R-type then jal back-to-back -> ALUOP=10 in EXECR, RegWrite=1 in both ALUWB cycles, ImmSrc=11 during jal.
